// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell reused over WIDTH cycles, LSB first,
// with start/done handshake, synchronous abort and registered result/carry outputs.
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             clear,
    input  logic [WIDTH-1:0] operand_a,
    input  logic [WIDTH-1:0] operand_b,
    input  logic             carry_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_r;
    logic [WIDTH-1:0] a_sr_r;
    logic [WIDTH-1:0] b_sr_r;
    logic [WIDTH-1:0] sum_sr_r;
    logic             carry_r;
    logic [CW-1:0]    cnt_r;

    logic [1:0]       fa_s;
    logic [WIDTH-1:0] sum_next_s;
    logic             last_s;
    logic             accept_s;

    // Returns {carry, sum} of a one-bit full adder.
    function automatic logic [1:0] full_add(input logic a, input logic b, input logic c);
        full_add = {(a & b) | (a & c) | (b & c), a ^ b ^ c};
    endfunction

    // Adder cell, next result shift value, last-bit and start-acceptance decode.
    always_comb begin
        fa_s                  = full_add(a_sr_r[0], b_sr_r[0], carry_r);
        sum_next_s            = sum_sr_r >> 1;
        sum_next_s[WIDTH-1]   = fa_s[0];
        last_s                = (cnt_r == CW'(WIDTH - 1));
        accept_s              = start && ((state_r == IDLE) || (state_r == DONE));
    end

    // Sequencer FSM with datapath registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            a_sr_r    <= '0;
            b_sr_r    <= '0;
            sum_sr_r  <= '0;
            carry_r   <= 1'b0;
            cnt_r     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
        end else if (clear) begin
            // Abort discards the partial sum; result/carry_out keep the last completion.
            state_r <= IDLE;
            cnt_r   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else if (accept_s) begin
            a_sr_r  <= operand_a;
            b_sr_r  <= operand_b;
            carry_r <= carry_in;
            cnt_r   <= '0;
            state_r <= ADD;
            busy    <= 1'b1;
            done    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                end
                ADD: begin
                    a_sr_r   <= a_sr_r >> 1;
                    b_sr_r   <= b_sr_r >> 1;
                    sum_sr_r <= sum_next_s;
                    carry_r  <= fa_s[1];
                    cnt_r    <= cnt_r + CW'(1);
                    if (last_s) begin
                        result    <= sum_next_s;
                        carry_out <= fa_s[1];
                        state_r   <= DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                    end else begin
                        busy <= 1'b1;
                        done <= 1'b0;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8): directed additions push expected
// {carry_out, result}; a monitor pops and compares on every done pulse.
module tb_serial_adder_ctrl;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         clear = 1'b0;
    logic [W-1:0] operand_a = '0;
    logic [W-1:0] operand_b = '0;
    logic         carry_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry_out;

    int checks = 0;
    int errors = 0;
    logic [W:0] exp_q[$];

    serial_adder_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .clear     (clear),
        .operand_a (operand_a),
        .operand_b (operand_b),
        .carry_in  (carry_in),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            chk("busy_low_during_done", {31'd0, busy}, 32'd0);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got result 0x%0h with no pending expectation at %0t",
                         result, $time);
            end else begin
                logic [W:0] e;
                e = exp_q.pop_front();
                chk("sum", {23'd0, carry_out, result}, {23'd0, e});
            end
        end
    end

    task automatic start_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                             input logic [W-1:0] er, input logic ec, input bit push, input bit hold);
        @(posedge clk);
        #1;
        operand_a = a;
        operand_b = b;
        carry_in  = cin;
        start     = 1'b1;
        if (push) exp_q.push_back({ec, er});
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int max_cyc, output int lat, output int busy_cnt);
        bit found;
        found    = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk);
            lat++;
            if (busy) busy_cnt++;
            if (done) begin
                found = 1'b1;
                break;
            end
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no done within %0d cycles expected done", name, max_cyc);
        end
    endtask

    initial begin
        int lat;
        int bc;
        #200000;
        $display("FAIL global_timeout: got simulation still running expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int bc;

        // Reset values
        #3;
        chk("reset_busy", {31'd0, busy}, 32'd0);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", {24'd0, result}, 32'd0);
        chk("reset_carry", {31'd0, carry_out}, 32'd0);
        #19 rst_n = 1'b1;

        // Test 1: 0x5A + 0x3C, latency and busy length
        start_add(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0);
        wait_done("t1", 20, lat, bc);
        chk("t1_latency", lat, 32'd9);
        chk("t1_busy_cycles", bc, 32'd8);

        // Test 2: carry generation
        start_add(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        wait_done("t2a", 20, lat, bc);
        start_add(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b0);
        wait_done("t2b", 20, lat, bc);
        chk("t2b_latency", lat, 32'd9);

        // Test 3: start held, operands change mid-ADD, back-to-back acceptance
        start_add(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1 operand_a = 8'h7F;
        wait_done("t3a", 20, lat, bc);
        exp_q.push_back({1'b0, 8'h9F});
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("t3_no_bubble_busy", {31'd0, busy}, 32'd1);
        wait_done("t3b", 20, lat, bc);
        chk("t3b_latency", lat, 32'd8);

        // Test 4: start pulses during ADD are ignored
        start_add(8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b1, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        start = 1'b1; operand_a = 8'hAA; operand_b = 8'h55; carry_in = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1 start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("t4", 20, lat, bc);
        chk("t4_latency_from_last_pulse", lat, 32'd4);
        repeat (12) @(negedge clk);

        // Test 5: clear mid-ADD keeps previous result; clear beats start in IDLE
        start_add(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1, 1'b0);
        wait_done("t5_pre", 20, lat, bc);
        start_add(8'h11, 8'h22, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1 clear = 1'b1;
        @(posedge clk);
        #1 clear = 1'b0;
        @(negedge clk);
        chk("t5_clear_busy", {31'd0, busy}, 32'd0);
        chk("t5_clear_done", {31'd0, done}, 32'd0);
        chk("t5_clear_result", {24'd0, result}, 32'h96);
        chk("t5_clear_carry", {31'd0, carry_out}, 32'd0);
        repeat (12) @(negedge clk);
        @(posedge clk);
        #1;
        clear = 1'b1; start = 1'b1; operand_a = 8'h01; operand_b = 8'h01; carry_in = 1'b0;
        @(posedge clk);
        #1;
        clear = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("t5_clear_start_busy", {31'd0, busy}, 32'd0);
        repeat (12) @(negedge clk);

        // Test 6: asynchronous reset mid-ADD
        start_add(8'h5A, 8'h3C, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", {31'd0, busy}, 32'd0);
        chk("t6_rst_done", {31'd0, done}, 32'd0);
        chk("t6_rst_result", {24'd0, result}, 32'd0);
        chk("t6_rst_carry", {31'd0, carry_out}, 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        start_add(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b1, 1'b0);
        wait_done("t6", 20, lat, bc);
        chk("t6_latency", lat, 32'd9);

        repeat (12) @(negedge clk);
        chk("pending_expectations", exp_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
